// File: rtl/hilo_seq_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
// Divide support is controlled by the HILO_SEQ_DIVU_EN macro in the other files.
package hilo_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic {
        OP_MULTU = 1'b0,
        OP_DIVU  = 1'b1
    } op_e;

    localparam int          ITER      = 32;
    localparam int          LATENCY   = 33;
    localparam int          CNT_W     = 6;
    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/hilo_seq_step.sv
// Combinational radix-2 iteration: shift-add for multu, restoring step for divu.
// The divu path exists only when HILO_SEQ_DIVU_EN is defined.
module hilo_step
    import hilo_seq_pkg::*;
(
    input  op_e         op_i,
    input  logic [63:0] acc_i,
    input  logic [31:0] operand_i,
    output logic [63:0] acc_o
);

    logic [32:0] add_sum;

    // Multiplier bits sit in acc[31:0] and shift out at the bottom as the product shifts in.
    assign add_sum = {1'b0, acc_i[63:32]} + (acc_i[0] ? {1'b0, operand_i} : 33'd0);

`ifdef HILO_SEQ_DIVU_EN
    logic [32:0] rem_sh;
    logic [32:0] trial;

    always_comb begin
        rem_sh = acc_i[63:31];
        trial  = rem_sh - {1'b0, operand_i};
        if (op_i == OP_DIVU) begin
            if (!trial[32]) begin
                acc_o = {trial[31:0], acc_i[30:0], 1'b1};
            end else begin
                acc_o = {rem_sh[31:0], acc_i[30:0], 1'b0};
            end
        end else begin
            acc_o = {add_sum, acc_i[31:1]};
        end
    end
`else
    logic unused_op;
    assign unused_op = op_i;
    assign acc_o     = {add_sum, acc_i[31:1]};
`endif

endmodule

// File: rtl/hilo_seq.sv
// Iterative multu/divu sequencer owning the architectural HI/LO registers.
// Divide support only when HILO_SEQ_DIVU_EN is defined; otherwise every op is multu.
module hilo_seq
    import hilo_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    input  logic        flush,
    input  logic        mf_req,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] HI_q,
    output logic [31:0] LO_q
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [63:0]        acc_q, acc_d, step_acc;
    logic [31:0]        opa_q, opa_d, opb_q, opb_d;
    logic [31:0]        hi_d, lo_d;
    op_e                op_q, op_d, op_in;
    logic               accept, last_iter;

`ifdef HILO_SEQ_DIVU_EN
    assign op_in = op_e'(op);
`else
    logic unused_op;
    assign unused_op = op;
    assign op_in     = OP_MULTU;
`endif

    assign accept    = start && !flush && (state_q == ST_IDLE || state_q == ST_DONE);
    assign last_iter = (state_q == ST_RUN) && (cnt_q == CNT_W'(ITER - 1));

    hilo_step u_step (
        .op_i      (op_q),
        .acc_i     (acc_q),
        .operand_i ((op_q == OP_DIVU) ? opb_q : opa_q),
        .acc_o     (step_acc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_RUN;
            ST_RUN: begin
                if (flush)          state_d = ST_IDLE;
                else if (last_iter) state_d = ST_DONE;
            end
            ST_DONE: state_d = accept ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy  = (state_q == ST_RUN);
        done  = (state_q == ST_DONE);
        stall = busy & (mf_req | start);
    end

    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        opa_d = opa_q;
        opb_d = opb_q;
        op_d  = op_q;
        hi_d  = HI_q;
        lo_d  = LO_q;
        if (accept) begin
            opa_d = opa;
            opb_d = opb;
            op_d  = op_in;
            cnt_d = '0;
            acc_d = {32'd0, (op_in == OP_DIVU) ? opa : opb};
        end else if (state_q == ST_RUN && !flush) begin
            acc_d = step_acc;
            cnt_d = cnt_q + CNT_W'(1);
            if (last_iter) begin
                hi_d = step_acc[63:32];
                lo_d = step_acc[31:0];
                // Divide by zero still runs all iterations; the result is fixed up at load.
                if (op_q == OP_DIVU && opb_q == 32'd0) begin
                    hi_d = opa_q;
                    lo_d = DIV0_QUOT;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            acc_q <= '0;
            opa_q <= '0;
            opb_q <= '0;
            op_q  <= OP_MULTU;
            HI_q  <= '0;
            LO_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            opa_q <= opa_d;
            opb_q <= opb_d;
            op_q  <= op_d;
            HI_q  <= hi_d;
            LO_q  <= lo_d;
        end
    end

endmodule

// File: tb/tb_hilo_seq.sv
// Self-checking bench for hilo_seq: behavioural HI/LO model plus directed literal checks.
module tb_hilo_seq;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b1;
    logic        start  = 1'b0;
    logic        op     = 1'b0;
    logic        flush  = 1'b0;
    logic        mf_req = 1'b0;
    logic [31:0] opa    = 32'd0;
    logic [31:0] opb    = 32'd0;
    wire         busy, stall, done;
    wire  [31:0] HI_q, LO_q;

    int tests = 0;
    int fails = 0;

`ifdef HILO_SEQ_DIVU_EN
    localparam bit DIVU_ON = 1'b1;
`else
    localparam bit DIVU_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    hilo_seq dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .opa    (opa),
        .opb    (opb),
        .flush  (flush),
        .mf_req (mf_req),
        .busy   (busy),
        .stall  (stall),
        .done   (done),
        .HI_q   (HI_q),
        .LO_q   (LO_q)
    );

    task automatic check1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result as {HI, LO} from plain arithmetic.
    function automatic logic [63:0] ref_result(input logic do_div, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        if (do_div) begin
            if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
            else            p = {a % b, a / b};
        end
        return p;
    endfunction

    // Model: an accepted op completes 32 cycles later unless flushed or reset.
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    int          m_left = 0;
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0, r_hi = 32'd0, r_lo = 32'd0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_left <= 0;
            m_hi   <= 32'd0;
            m_lo   <= 32'd0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (flush) begin
                    m_busy <= 1'b0;
                end else if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_hi   <= r_hi;
                    m_lo   <= r_lo;
                end else begin
                    m_left <= m_left - 1;
                end
            end else if (start && !flush) begin
                m_busy <= 1'b1;
                m_left <= 32;
                {r_hi, r_lo} <= ref_result(op & DIVU_ON, opa, opb);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #3;
            check1 ("cmp_busy",  busy,  m_busy);
            check1 ("cmp_done",  done,  m_done);
            check1 ("cmp_stall", stall, m_busy & (mf_req | start));
            check32("cmp_hi",    HI_q,  m_hi);
            check32("cmp_lo",    LO_q,  m_lo);
        end
    end

    task automatic wait_done(output int edges, output bit got, output int stalls);
        edges  = 0;
        got    = 1'b0;
        stalls = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk);
            edges++;
            #1;
            if (stall) stalls++;
            if (done)  got = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                          output int edges, output bit got, output int stalls);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        opa   = a;
        opb   = b;
        wait_done(edges, got, stalls);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int edges, stalls, pulses;
        bit got;

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check1 ("rst_busy",  busy,  1'b0);
        check1 ("rst_done",  done,  1'b0);
        check1 ("rst_stall", stall, 1'b0);
        check32("rst_hi",    HI_q,  32'd0);
        check32("rst_lo",    LO_q,  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(1'b0, 32'hFFFF_FFFF, 32'h2, edges, got, stalls);
        check1 ("mul_ff_done", got, 1'b1);
        check32("mul_ff_latency", 32'(edges), 32'd33);
        check32("mul_ff_hi", HI_q, 32'h1);
        check32("mul_ff_lo", LO_q, 32'hFFFF_FFFE);

        run_op(1'b1, 32'd100, 32'd7, edges, got, stalls);
        check1 ("div_100_7_done", got, 1'b1);
        check32("div_100_7_lo", LO_q, DIVU_ON ? 32'd14 : 32'd700);
        check32("div_100_7_hi", HI_q, DIVU_ON ? 32'd2  : 32'd0);

        run_op(1'b1, 32'd5, 32'd0, edges, got, stalls);
        check1 ("div0_done", got, 1'b1);
        check32("div0_latency", 32'(edges), 32'd33);
        check32("div0_lo", LO_q, DIVU_ON ? 32'hFFFF_FFFF : 32'd0);
        check32("div0_hi", HI_q, DIVU_ON ? 32'd5 : 32'd0);

        mf_req = 1'b1;
        run_op(1'b0, 32'd3, 32'd4, edges, got, stalls);
        mf_req = 1'b0;
        check1 ("mf_done", got, 1'b1);
        check32("mf_stall_cycles", 32'(stalls), 32'd32);
        check32("mf_hi", HI_q, 32'd0);
        check32("mf_lo", LO_q, 32'd12);

        run_op(1'b0, 32'h8000_0001, 32'd2, edges, got, stalls);
        check32("pre_hi", HI_q, 32'd1);
        check32("pre_lo", LO_q, 32'd2);
        @(negedge clk);
        start = 1'b1; op = 1'b0; opa = 32'd6; opb = 32'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check1("flush_busy", busy, 1'b0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check32("flush_pulses", 32'(pulses), 32'd0);
        check32("flush_hi", HI_q, 32'd1);
        check32("flush_lo", LO_q, 32'd2);

        @(negedge clk);
        start = 1'b1; op = 1'b0; opa = 32'd9; opb = 32'd9;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        mf_req = 1'b1;
        start  = 1'b1;
        rst_n  = 1'b0;
        #1;
        check1 ("mid_rst_busy",  busy,  1'b0);
        check1 ("mid_rst_done",  done,  1'b0);
        check1 ("mid_rst_stall", stall, 1'b0);
        check32("mid_rst_hi",    HI_q,  32'd0);
        check32("mid_rst_lo",    LO_q,  32'd0);
        @(negedge clk);
        rst_n = 1'b1; mf_req = 1'b0;
        start = 1'b1; op = 1'b0; opa = 32'd2; opb = 32'd3;
        wait_done(edges, got, stalls);
        check1 ("post_rst_done", got, 1'b1);
        check32("post_rst_latency", 32'(edges), 32'd33);
        check32("post_rst_hi", HI_q, 32'd0);
        check32("post_rst_lo", LO_q, 32'd6);

        repeat (3000) begin
            @(negedge clk);
            start  = ($urandom_range(0, 3) == 0);
            op     = 1'($urandom_range(0, 1));
            opa    = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            opb    = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            flush  = ($urandom_range(0, 199) == 0);
            mf_req = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        start = 1'b0; flush = 1'b0; mf_req = 1'b0;
        repeat (40) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hilo_seq.md
HILO_SEQ -- requirements
Module: hilo_seq

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-003 The block SHALL have port start, input, 1 bit: EX-stage multu_en/divu request, sampled at the rising edge.
REQ-004 The block SHALL have port op, input, 1 bit: 0=multu, 1=divu.
REQ-005 The block SHALL have ports opa and opb, input, 32 bits each: unsigned operands (multiplicand/dividend, multiplier/divisor).
REQ-006 The block SHALL have port flush, input, 1 bit: pipeline flush; aborts the in-flight operation.
REQ-007 The block SHALL have port mf_req, input, 1 bit: an mfhi/mflo instruction is in decode.
REQ-008 The block SHALL have port busy, output, 1 bit: an operation is in progress.
REQ-009 The block SHALL have port stall, output, 1 bit: hold the upstream pipeline stages.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse when HI/LO update.
REQ-011 The block SHALL have ports HI_q and LO_q, output, 32 bits each: architectural HI/LO registers.

Function
REQ-012 The FSM SHALL have 3 states: IDLE, RUN, DONE.
REQ-013 In IDLE, start=1 with flush=0 SHALL latch opa, opb and op, clear the 6-bit iteration counter, and enter RUN.
REQ-014 RUN SHALL process one operand bit per cycle, incrementing the counter each cycle, and SHALL enter DONE after exactly 32 RUN cycles.
REQ-015 multu SHALL use radix-2 shift-add into a 64-bit accumulator; the result SHALL be HI={acc[63:32]} and LO={acc[31:0]}.
REQ-016 divu SHALL use radix-2 restoring division; the result SHALL be LO=quotient and HI=remainder.
REQ-017 divu with opb=0 SHALL give LO=32'hFFFFFFFF and HI=opa, still with the full 32-cycle latency.
REQ-018 On the DONE-entry edge, HI_q/LO_q SHALL load; done=1 for that one cycle; the next state SHALL be IDLE.
REQ-019 Latency SHALL be 33 edges: from the edge that samples start to the edge that loads HI/LO.
REQ-020 busy SHALL be 1 in RUN and 0 in IDLE and DONE.
REQ-021 stall SHALL be busy & (mf_req | start), and SHALL be combinational.
REQ-022 start while busy SHALL be ignored (not queued), and SHALL assert stall until the block is no longer busy.
REQ-023 In DONE, start=1 SHALL be accepted as in IDLE, giving back-to-back operation with no bubble.
REQ-024 flush=1 in RUN or DONE SHALL return the FSM to IDLE, leave HI_q/LO_q unchanged, and keep done=0.
REQ-025 flush has priority over start on the same edge.
REQ-026 HI_q/LO_q SHALL change only on the DONE-entry edge or on reset.

Reset
REQ-027 rst_n=0 SHALL immediately force: state IDLE, counter 0, accumulator 0, HI_q=0, LO_q=0, busy=0, done=0, stall=0.
REQ-028 Reset mid-operation SHALL discard the operation with no HI/LO update.
REQ-029 The first start SHALL be accepted on the first edge after rst_n deasserts.

Configuration
REQ-030 The macro HILO_SEQ_DIVU_EN SHALL control divide support.
REQ-031 With HILO_SEQ_DIVU_EN defined, the divider datapath is built and op selects multu or divu.
REQ-032 Without HILO_SEQ_DIVU_EN, the divider logic is absent, op is ignored, and every start SHALL perform multu.

Structure
REQ-033 A shared package SHALL hold: the FSM state encoding (2 bits), the op encoding (OP_MULTU=0, OP_DIVU=1), the ITER constant (32), and the divide-by-zero quotient constant.
REQ-034 The package SHALL also hold the fixed 33-cycle latency constant.
REQ-035 The per-iteration add/subtract-shift step SHALL be one sub-module, hilo_step, that is purely combinational.
REQ-036 The FSM, counter and HI/LO registers SHALL be in hilo_seq.

Verification
REQ-037 The bench SHALL apply multu opa=32'hFFFFFFFF, opb=32'h2 and require HI_q=32'h1 and LO_q=32'hFFFFFFFE, with done 33 edges after start.
REQ-038 The bench SHALL apply divu opa=100, opb=7 (HILO_SEQ_DIVU_EN defined) and require LO_q=14 and HI_q=2.
REQ-039 The bench SHALL apply divu opa=5, opb=0 and require LO_q=32'hFFFFFFFF and HI_q=5.
REQ-040 The bench SHALL start multu 3*4, assert mf_req during RUN, and require stall=1 until the update with HI_q=0 and LO_q=12 after.
REQ-041 The bench SHALL load HI/LO from a prior op (HI=1, LO=2), then start 6*7 and assert flush at RUN cycle 10; the block SHALL return to IDLE with HI_q=1, LO_q=2 and no done pulse.
REQ-042 The bench SHALL pull rst_n low at RUN cycle 20 and require all outputs 0 immediately, then a fresh multu 2*3 giving LO_q=6.
